// File: rtl/scoot_bot_pkg.sv
// Shared types and helpers for the scoot robot heading controller.
// Holds the FSM state enum, round-robin scan and one-hot helpers, and default parameter values.
package scoot_bot_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MOVE = 1'b1
    } state_t;

    localparam int DEF_NUM_DIRS = 4;
    localparam int DEF_PERSIST  = 2;
    localparam int DEF_SCORE_W  = 8;
    localparam int DEF_MAX_RUN  = 16;

    // Helpers operate on a fixed-width vector; callers zero-extend and truncate.
    localparam int MAX_DIRS = 32;
    localparam int IDX_W    = 5;

    // First set bit of act, scanning upward from start with wrap at numDirs.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_DIRS-1:0] act,
                                                 input logic [IDX_W-1:0]    start,
                                                 input int                  numDirs);
        logic [IDX_W:0] idx;
        logic           found;
        rr_pick = start;
        found   = 1'b0;
        for (int i = 0; i < MAX_DIRS; i++) begin
            idx = {1'b0, start} + (IDX_W+1)'(i);
            if (idx >= (IDX_W+1)'(numDirs)) idx = idx - (IDX_W+1)'(numDirs);
            if ((i < numDirs) && !found && act[idx[IDX_W-1:0]]) begin
                rr_pick = idx[IDX_W-1:0];
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [MAX_DIRS-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/scoot_persist_cnt.sv
// One direction's persistence counter: reloads on sense, counts down otherwise.
// active stays high while the sensor is lit or the counter is still non-zero.
module scoot_persist_cnt
    import scoot_bot_pkg::*;
#(
    parameter int PERSIST = DEF_PERSIST
) (
    input  logic clock,
    input  logic resetN,
    input  logic sense,
    output logic active
);

    localparam int CW = $clog2(PERSIST + 1);

    logic [CW-1:0] cnt;

    // Reload takes priority over the decrement on the same cycle.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            cnt <= '0;
        end else if (sense) begin
            cnt <= CW'(PERSIST);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign active = sense | (cnt != '0);

endmodule

// File: rtl/scoot_bot_ctrl.sv
// Single-heading motor arbiter with per-direction persistence, round-robin ties and a pickup score.
// Define SCOOT_BOT_RUN_LIMIT_EN to force a heading change after MAX_RUN cycles when another direction is active.
module scoot_bot_ctrl
    import scoot_bot_pkg::*;
#(
    parameter int NUM_DIRS = DEF_NUM_DIRS,
    parameter int PERSIST  = DEF_PERSIST,
    parameter int SCORE_W  = DEF_SCORE_W,
    parameter int MAX_RUN  = DEF_MAX_RUN
) (
    input  logic                        clock,
    input  logic                        resetN,
    input  logic                        enable,
    input  logic [NUM_DIRS-1:0]         sense,
    input  logic                        pickup,
    output logic [NUM_DIRS-1:0]         move,
    output logic [$clog2(NUM_DIRS)-1:0] heading,
    output logic                        moving,
    output logic [SCORE_W-1:0]          score
);

    localparam int HW = $clog2(NUM_DIRS);

    if (NUM_DIRS < 2 || NUM_DIRS > MAX_DIRS || PERSIST < 1 || MAX_RUN < 2) begin : g_bad_params
        $error("scoot_bot_ctrl: parameter out of range");
    end

    state_t              state, stateNext;
    logic [NUM_DIRS-1:0] act, moveNext;
    logic [HW-1:0]       rrPtr, headNext, grantIdx, pickRr, pickSw, nextHead;
    logic [MAX_DIRS-1:0] actWide, actOther;
    logic                grant, otherAny;

`ifdef SCOOT_BOT_RUN_LIMIT_EN
    localparam int RW = $clog2(MAX_RUN);
    logic [RW-1:0] runCnt, runNext;
`endif

    for (genvar d = 0; d < NUM_DIRS; d++) begin : g_persist
        scoot_persist_cnt #(.PERSIST(PERSIST)) u_cnt (
            .clock  (clock),
            .resetN (resetN),
            .sense  (sense[d]),
            .active (act[d])
        );
    end

    // Switching scans from heading+1 with the current heading masked out.
    always_comb begin
        actWide                 = '0;
        actWide[NUM_DIRS-1:0]   = act;
        actOther                = actWide & ~onehot(IDX_W'(heading));
        otherAny                = |actOther;
        nextHead                = (heading == HW'(NUM_DIRS - 1)) ? '0 : heading + HW'(1);
        pickRr                  = HW'(rr_pick(actWide, IDX_W'(rrPtr), NUM_DIRS));
        pickSw                  = HW'(rr_pick(actOther, IDX_W'(nextHead), NUM_DIRS));
    end

    always_comb begin
        stateNext = state;
        moveNext  = move;
        headNext  = heading;
        grant     = 1'b0;
        grantIdx  = pickSw;
`ifdef SCOOT_BOT_RUN_LIMIT_EN
        runNext   = runCnt;
`endif
        case (state)
            IDLE: begin
                if (enable && (|act)) begin
                    stateNext = MOVE;
                    grant     = 1'b1;
                    grantIdx  = pickRr;
                end else begin
                    moveNext = '0;
                end
            end
            MOVE: begin
                if (!enable) begin
                    stateNext = IDLE;
                    moveNext  = '0;
                end else if (act[heading]) begin
`ifdef SCOOT_BOT_RUN_LIMIT_EN
                    if (runCnt == RW'(MAX_RUN - 1)) begin
                        grant = otherAny;
                    end else begin
                        runNext = runCnt + RW'(1);
                    end
`endif
                end else if (|act) begin
                    grant = 1'b1;
                end else begin
                    stateNext = IDLE;
                    moveNext  = '0;
                end
            end
        endcase
        if (grant) begin
            headNext           = grantIdx;
            moveNext           = '0;
            moveNext[grantIdx] = 1'b1;
`ifdef SCOOT_BOT_RUN_LIMIT_EN
            runNext            = '0;
`endif
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            move    <= '0;
            heading <= '0;
            rrPtr   <= '0;
            score   <= '0;
`ifdef SCOOT_BOT_RUN_LIMIT_EN
            runCnt  <= '0;
`endif
        end else begin
            state   <= stateNext;
            move    <= moveNext;
            heading <= headNext;
            if (grant) begin
                rrPtr <= (grantIdx == HW'(NUM_DIRS - 1)) ? '0 : grantIdx + HW'(1);
            end
            if (pickup && (score != '1)) begin
                score <= score + SCORE_W'(1);
            end
`ifdef SCOOT_BOT_RUN_LIMIT_EN
            runCnt  <= runNext;
`endif
        end
    end

    assign moving = (state == MOVE);

endmodule

// File: tb/tb_scoot_bot_ctrl.sv
// Self-checking bench for scoot_bot_ctrl (NUM_DIRS=4, PERSIST=2, SCORE_W=4, MAX_RUN=8).
// Directed scenarios use spec-derived constants; the random run uses a timestamp-based reference model.
module tb_scoot_bot_ctrl;

    localparam int ND      = 4;
    localparam int PERSIST = 2;
    localparam int SCORE_W = 4;
    localparam int MAX_RUN = 8;

    logic         clock = 1'b0;
    logic         resetN;
    logic         enable;
    logic [3:0]   sense;
    logic         pickup;
    logic [3:0]   move;
    logic [1:0]   heading;
    logic         moving;
    logic [3:0]   score;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [10:0] exp_q[$];

    // Reference model state: last edge each sensor was seen high, plus arbiter view.
    int         lastHigh[ND];
    int         edgeNo = 0;
    bit         mMoving;
    int         mHead, mRr, mRun, mScore;
    logic [3:0] mMove;

    scoot_bot_ctrl #(
        .NUM_DIRS (ND),
        .PERSIST  (PERSIST),
        .SCORE_W  (SCORE_W),
        .MAX_RUN  (MAX_RUN)
    ) dut (
        .clock   (clock),
        .resetN  (resetN),
        .enable  (enable),
        .sense   (sense),
        .pickup  (pickup),
        .move    (move),
        .heading (heading),
        .moving  (moving),
        .score   (score)
    );

    always #5 clock = ~clock;

    task automatic modelReset();
        for (int d = 0; d < ND; d++) lastHigh[d] = -100;
        mMoving = 0;
        mHead   = 0;
        mRr     = 0;
        mRun    = 0;
        mScore  = 0;
        mMove   = 4'b0000;
    endtask

    function automatic int scanFrom(input logic [3:0] a, input int start, input int excl);
        for (int k = 0; k < ND; k++) begin
            int i;
            i = (start + k) % ND;
            if (a[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic grantTo(input int i);
        mMoving = 1;
        mHead   = i;
        mMove   = 4'b0001 << i;
        mRr     = (i + 1) % ND;
        mRun    = 1;
    endtask

    task automatic modelEdge(input logic [3:0] s, input logic en, input logic pk);
        logic [3:0] a;
        bit any, other;
        edgeNo++;
        any   = 0;
        other = 0;
        for (int d = 0; d < ND; d++) begin
            a[d] = s[d] || (edgeNo - lastHigh[d] <= PERSIST);
            if (s[d]) lastHigh[d] = edgeNo;
            if (a[d]) any = 1;
            if (a[d] && d != mHead) other = 1;
        end
        if (!mMoving) begin
            if (en && any) grantTo(scanFrom(a, mRr, -1));
            else mMove = 4'b0000;
        end else if (!en) begin
            mMoving = 0;
            mMove   = 4'b0000;
        end else if (a[mHead]) begin
`ifdef SCOOT_BOT_RUN_LIMIT_EN
            if (mRun >= MAX_RUN && other) grantTo(scanFrom(a, (mHead + 1) % ND, mHead));
            else mRun++;
`else
            mRun++;
`endif
        end else if (any) begin
            grantTo(scanFrom(a, (mHead + 1) % ND, -1));
        end else begin
            mMoving = 0;
            mMove   = 4'b0000;
        end
        if (pk && mScore < 15) mScore++;
        exp_q.push_back({mMoving, 2'(mHead), mMove, 4'(mScore)});
    endtask

    // Drive on the falling edge, update the model at the rising edge, return 1 time unit later.
    task automatic step(input logic [3:0] s, input logic en, input logic pk);
        @(negedge clock);
        sense  = s;
        enable = en;
        pickup = pk;
        @(posedge clock);
        modelEdge(s, en, pk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clock);
        resetN = 1'b0;
        sense  = '0;
        enable = 1'b0;
        pickup = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;
        modelReset();
        exp_q.delete();
    endtask

    task automatic test_reset();
        doReset();
        nCompared++;
        if (move !== 4'b0000) begin nMismatched++; $display("FAIL reset_move: got %b want 0000", move); end
        nCompared++;
        if (heading !== 2'd0) begin nMismatched++; $display("FAIL reset_heading: got %0d want 0", heading); end
        nCompared++;
        if (moving !== 1'b0) begin nMismatched++; $display("FAIL reset_moving: got %b want 0", moving); end
        nCompared++;
        if (score !== 4'd0) begin nMismatched++; $display("FAIL reset_score: got %0d want 0", score); end
    endtask

    task automatic test_single_pulse();
        logic [3:0] sIn [4]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0] want [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
        doReset();
        for (int k = 0; k < 4; k++) begin
            step(sIn[k], 1'b1, 1'b0);
            nCompared++;
            if (move !== want[k]) begin nMismatched++; $display("FAIL pulse_move cyc%0d: got %b want %b", k, move, want[k]); end
            nCompared++;
            if (moving !== (|want[k])) begin nMismatched++; $display("FAIL pulse_moving cyc%0d: got %b want %b", k, moving, |want[k]); end
        end
    endtask

    task automatic test_tie();
        logic [3:0] sIn [4]  = '{4'b0101, 4'b0100, 4'b0100, 4'b0100};
        logic [3:0] want [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0100};
        doReset();
        for (int k = 0; k < 4; k++) begin
            step(sIn[k], 1'b1, 1'b0);
            nCompared++;
            if (move !== want[k]) begin nMismatched++; $display("FAIL tie_move cyc%0d: got %b want %b", k, move, want[k]); end
            nCompared++;
            if (moving !== 1'b1) begin nMismatched++; $display("FAIL tie_gap cyc%0d: got moving %b want 1", k, moving); end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] sIn [9]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0101,
                                 4'b0000, 4'b0000, 4'b0000, 4'b0101};
        logic [3:0] want [9] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001,
                                 4'b0001, 4'b0001, 4'b0000, 4'b0100};
        doReset();
        for (int k = 0; k < 9; k++) begin
            step(sIn[k], 1'b1, 1'b0);
            nCompared++;
            if (move !== want[k]) begin nMismatched++; $display("FAIL rr_move cyc%0d: got %b want %b", k, move, want[k]); end
        end
    endtask

    task automatic test_enable_drop();
        logic       enIn [3] = '{1'b1, 1'b0, 1'b1};
        logic [3:0] want [3] = '{4'b0010, 4'b0000, 4'b0010};
        doReset();
        for (int k = 0; k < 3; k++) begin
            step(4'b0010, enIn[k], 1'b0);
            nCompared++;
            if (move !== want[k]) begin nMismatched++; $display("FAIL endrop_move cyc%0d: got %b want %b", k, move, want[k]); end
            nCompared++;
            if (heading !== 2'd1) begin nMismatched++; $display("FAIL endrop_heading cyc%0d: got %0d want 1", k, heading); end
            nCompared++;
            if (moving !== enIn[k]) begin nMismatched++; $display("FAIL endrop_moving cyc%0d: got %b want %b", k, moving, enIn[k]); end
        end
    endtask

    task automatic test_score_async_reset();
        doReset();
        for (int k = 1; k <= 17; k++) begin
            step(4'b0000, 1'b1, 1'b1);
            nCompared++;
            if (score !== 4'((k < 15) ? k : 15)) begin
                nMismatched++;
                $display("FAIL score_count pulse%0d: got %0d want %0d", k, score, (k < 15) ? k : 15);
            end
        end
        step(4'b0001, 1'b1, 1'b0);
        nCompared++;
        if (move !== 4'b0001) begin nMismatched++; $display("FAIL areset_pre_move: got %b want 0001", move); end
        resetN = 1'b0;
        #1;
        nCompared++;
        if (move !== 4'b0000) begin nMismatched++; $display("FAIL areset_move: got %b want 0000", move); end
        nCompared++;
        if (score !== 4'd0) begin nMismatched++; $display("FAIL areset_score: got %0d want 0", score); end
        nCompared++;
        if (moving !== 1'b0) begin nMismatched++; $display("FAIL areset_moving: got %b want 0", moving); end
        @(negedge clock);
        resetN = 1'b1;
        modelReset();
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [3:0]  s;
        logic [10:0] want, got;
        doReset();
        for (int k = 0; k < 400; k++) begin
            for (int d = 0; d < ND; d++) s[d] = ($urandom_range(0, 3) == 0);
            step(s, ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0));
            got = {moving, heading, move, score};
            nCompared++;
            if (exp_q.size() == 0) begin
                nMismatched++;
                $display("FAIL rand_queue cyc%0d: got empty queue want one entry", k);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    nMismatched++;
                    $display("FAIL rand_state cyc%0d: got mv=%b hd=%0d move=%b sc=%0d want mv=%b hd=%0d move=%b sc=%0d",
                             k, got[10], got[9:8], got[7:4], got[3:0], want[10], want[9:8], want[7:4], want[3:0]);
                end
            end
            nCompared++;
            if ($countones(move) > 1) begin nMismatched++; $display("FAIL rand_onehot cyc%0d: got %b want at most one bit", k, move); end
        end
    endtask

`ifdef SCOOT_BOT_RUN_LIMIT_EN
    task automatic test_run_limit();
        logic [3:0] want;
        doReset();
        for (int k = 1; k <= 9; k++) begin
            step(4'b0011, 1'b1, 1'b0);
            want = (k <= MAX_RUN) ? 4'b0001 : 4'b0010;
            nCompared++;
            if (move !== want) begin nMismatched++; $display("FAIL runlim_switch cyc%0d: got %b want %b", k, move, want); end
        end
        doReset();
        for (int k = 1; k <= 20; k++) begin
            step(4'b0001, 1'b1, 1'b0);
            nCompared++;
            if (move !== 4'b0001) begin nMismatched++; $display("FAIL runlim_hold cyc%0d: got %b want 0001", k, move); end
        end
    endtask
`endif

    initial begin
        resetN = 1'b0;
        sense  = '0;
        enable = 1'b0;
        pickup = 1'b0;
        modelReset();
        test_reset();
        test_single_pulse();
        test_tie();
        test_round_robin();
        test_enable_drop();
        test_score_async_reset();
`ifdef SCOOT_BOT_RUN_LIMIT_EN
        test_run_limit();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/scoot_bot_ctrl.md
Name: scoot_bot_ctrl

Overview:
- Parametrised successor to the fixed four-direction scoot robot controller.
- Generalises to NUM_DIRS sensor/motor channels with a programmable persistence window per direction.
- Adds a registered single-heading arbiter (one-hot motor output), round-robin tie-breaking and a saturating pickup score counter.
- Sits between the light-sensor sampling logic and the motor/position update in the robot simulator.

Parameters:
- NUM_DIRS, 4, number of sensor/motor directions (>=2).
- PERSIST, 2, cycles a direction stays active after its sensor falls (>=1).
- SCORE_W, 8, width of the saturating pickup score counter.
- MAX_RUN, 16, maximum consecutive cycles on one heading (used only with the optional feature).

Ports:
- clock  input  1  system clock, rising edge.
- resetN  input  1  asynchronous active-low reset.
- enable  input  1  motion enable; when low, no heading is granted.
- sense  input  NUM_DIRS  light-sensor levels, bit d = direction d.
- pickup  input  1  single-cycle pulse: item collected this cycle.
- move  output  NUM_DIRS  registered one-hot motor command, or all zero.
- heading  output  $clog2(NUM_DIRS)  index of current or last granted direction.
- moving  output  1  registered; high when FSM state is MOVE.
- score  output  SCORE_W  saturating count of pickup pulses.

Behaviour:
- Reset (resetN low, asynchronous): move=0, heading=0, moving=0, score=0, every cnt[d]=0, rrPtr=0, runCnt=0, state=IDLE. Applies immediately, including mid-MOVE.
- Persistence counter per direction, width $clog2(PERSIST+1):
  - sense[d]=1 -> cnt[d]<=PERSIST.
  - Otherwise, if cnt[d]!=0 -> cnt[d]<=cnt[d]-1.
  - Otherwise hold 0.
  - Counters update every cycle, independent of enable.
- Active vector (combinational): act[d] = sense[d] | (cnt[d]!=0).
- Latency: sense rising in cycle t -> move visible from cycle t+1. A one-cycle pulse keeps move asserted for PERSIST+1 cycles.
- Round-robin pick: scan act starting at rrPtr, incrementing with wrap modulo NUM_DIRS; select the first set bit. Every grant sets rrPtr <= granted index+1 mod NUM_DIRS.
- FSM state IDLE:
  - enable & |act -> MOVE; heading <= pick; move <= onehot(pick); runCnt <= 0.
  - Otherwise move <= 0.
- FSM state MOVE:
  - !enable -> IDLE, move <= 0. Heading holds its last value.
  - act[heading] -> stay; move unchanged; runCnt saturating-increments.
  - !act[heading] & |act -> switch. The scan starts at heading+1 (not rrPtr); new heading and onehot; runCnt <= 0.
  - No act -> IDLE, move <= 0.
- move is never more than one-hot. Opposing directions are not cancelled; arbitration alone resolves them.
- Score: pickup=1 and score != 2^SCORE_W-1 -> score+1; at max, hold. Updates regardless of enable or state.
- Simultaneous events: a sense edge and a counter decrement on the same direction -> reload wins. enable falling on the same cycle act rises -> stay IDLE.

Optional Feature:
- Macro: SCOOT_BOT_RUN_LIMIT_EN.
- Defined:
  - In MOVE, when runCnt reaches MAX_RUN-1 and some other direction is active, force a switch using the same scan from heading+1. The current heading is excluded.
  - If no other direction is active, stay on the current heading; runCnt saturates at MAX_RUN-1.
  - runCnt width is $clog2(MAX_RUN).
- Undefined: no run limit; MAX_RUN is ignored; runCnt logic may be removed.

Decomposition:
- Package scoot_bot_pkg holds:
  - state enum {IDLE, MOVE};
  - function rr_pick(act, start) returning the index;
  - function onehot(idx);
  - default parameter constants.
- One sub-module, scoot_persist_cnt: a single-direction reload/decrement counter producing act[d]. It is instantiated NUM_DIRS times via generate.

Test Plan (NUM_DIRS=4, PERSIST=2, SCORE_W=4):
- Single pulse: sense=0001 for one cycle at t, enable=1 -> move=0001 in cycles t+1..t+3; move=0 at t+4; moving tracks move.
- Tie: from reset, sense=0101 held -> move=0001. Drop bit0 -> move=0100 after PERSIST+1 cycles, with no gap cycle.
- Round robin: reach IDLE after a heading-2 grant, then apply sense=0101 -> move=0001 (rrPtr=3 wraps to 0). A later heading-0 grant followed by IDLE and sense=0101 -> move=0100.
- Enable drop: in MOVE heading 1, enable=0 -> move=0 next cycle; heading stays 1. Re-enable with sense=0010 -> move=0010.
- Score: 17 pickup pulses -> score=15. Assert resetN=0 mid-MOVE without a clock edge -> move=0 and score=0 immediately.
- Macro on, MAX_RUN=8: sense=0011 held -> move=0001 for 8 cycles, then 0010. With sense=0001 only -> move stays 0001 indefinitely.
